proc_ctrl: RTL
==============

# proc_ctrl

Control unit for the team's simple bus-based processor: it fetches a 9-bit instruction from `DIN`, sequences it over up to four time steps, and drives the load enables (`Rin` of each `regn` register, `IRin`, `Ain`, `Gin`) and the bus-source selects. It sits directly upstream of the `regn` register file and the A/G accumulator registers. It produces every `Rin` strobe those registers consume. It performs no arithmetic itself; the datapath adder and bus mux act on its `AddSub`/`*out` outputs.

## Interface
- `OPW`, default 3: opcode field width.
- `RW`, default 3: register-select field width. `NREG = 2**RW` general registers; instruction width `IW = OPW + 2*RW` (9 at defaults).
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `DIN`, input, IW: instruction word in T0; immediate data in T1 of `mvi`.
- `Run`, input, 1: start request, sampled only in T0.
- `Rin`, output, NREG: one-hot load enables for R0..R(NREG-1); bit i drives the `Rin` input of register i.
- `Rout`, output, NREG: one-hot bus-source select for R0..R(NREG-1).
- `IRin`, output, 1: internal instruction register load, observable for debug.
- `Ain`, output, 1: A register load enable.
- `Gin`, output, 1: G register load enable.
- `Gout`, output, 1: G drives the bus.
- `DINout`, output, 1: `DIN` drives the bus.
- `AddSub`, output, 1: 0 selects add, 1 selects subtract.
- `Done`, output, 1: one-cycle pulse in the final step of an instruction.

## Operation
- Instruction format is `IR[IW-1 -: OPW]` = opcode, then X field (RW bits), then Y field (RW bits).
- Opcodes:
  - 000: `mv Rx,Ry`.
  - 001: `mvi Rx,#D`.
  - 010: `add Rx,Ry`.
  - 011: `sub Rx,Ry`.
  - 1xx: reserved; executes as a no-op.
- State register holds `Tstep` in {T0, T1, T2, T3} (2-bit) and internal `IR` (IW bits).
- T0:
  - `IRin = Run`.
  - If `Run`: IR ← DIN, next T1. Otherwise stay in T0.
- T1:
  - mv: `Rout = onehot(Y)`, `Rin = onehot(X)`, `Done`; next T0.
  - mvi: `DINout`, `Rin = onehot(X)`, `Done`; next T0.
  - add/sub: `Rout = onehot(X)`, `Ain`; next T2.
  - reserved: `Done` only; next T0.
- T2 (add/sub only):
  - `Rout = onehot(Y)`, `Gin`, `AddSub = (opcode == 011)`; next T3.
- T3 (add/sub only):
  - `Gout`, `Rin = onehot(X)`, `Done`; next T0.
- All outputs are combinational decodes of (`Tstep`, `IR`, `Run`). Any output not listed for a step is 0.
- Bus exclusivity: at most one of {`Rout` bits, `Gout`, `DINout`} is 1 in any cycle. At most one `Rin` bit is 1.
- X == Y is legal. `mv R3,R3` asserts `Rout[3]` and `Rin[3]` together.
- `Run` outside T0 is ignored; an instruction always runs to completion.

## Timing
- Reset (asynchronous, `resetn` = 0):
  - `Tstep` = T0 and `IR` = 0 immediately.
  - All outputs are 0, except `IRin`, which follows `Run` combinationally.
- Reset mid-instruction: enables drop in the same cycle; no partial write completes after reset. After `resetn` rises, the first `Run` sampled in T0 fetches.
- Latency from the fetch edge (the T0 edge with `Run` = 1):
  - mv, mvi, reserved: `Done` in the next cycle (T1); 2 cycles total per instruction.
  - add, sub: `Done` in T3; 4 cycles total.
- `mvi` immediate: the datapath presents it on `DIN` during the T1 cycle and the target register captures it at the end of T1.
- Back-to-back instructions: with `Done` in cycle k and `Run` held high, the next fetch occurs at the end of cycle k+1 (T0). Throughput is one instruction per 2 or 4 cycles.
- `Tstep` wraps T3 → T0 only; T0 advances only on `Run`.

## Structure
- Shared package `proc_pkg`:
  - Opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`.
  - `Tstep` encodings `T0`..`T3`.
  - `OPW`/`RW` defaults.
- Sub-module `dec_onehot`: parameterised RW → 2**RW decoder with enable. Instantiated twice, for the X and Y fields.
- The `Tstep` counter and `IR` live in `proc_ctrl`. No further hierarchy.

## Test plan
- Reset/idle: `resetn` = 0 with `Run` = 1, then release with `Run` = 0 for 5 cycles -> all outputs 0 except `IRin` = `Run`; `Tstep` stays T0.
- mvi: `DIN` = 9'b001_010_000 with `Run` for 1 cycle, then `DIN` = 9'h05A -> in T1, `DINout` = 1, `Rin` = 8'b0000_0100, `Done` = 1. A `regn` model of R2 holds 0x5A afterwards.
- mv: `DIN` = 9'b000_101_010 -> in T1, `Rout` = 8'b0000_0100, `Rin` = 8'b0010_0000, `Done` = 1; exactly 2 cycles.
- add then sub back-to-back with `Run` held high:
  - `add R1,R3`, then `sub R1,R1`.
  - T1: `Rout[1]`, `Ain`. T2: `Rout[3]`, `Gin`, `AddSub` = 0. T3: `Gout`, `Rin[1]`, `Done`.
  - The second fetch follows 1 cycle after `Done`; in its T2, `AddSub` = 1.
- Reset mid-add: assert `resetn` = 0 during T2 -> `Gin`/`Rout` drop in the same cycle; `Done` is never seen; after release, `Tstep` = T0.
- Reserved opcode 9'b110_000_000 -> only `Done` in T1. A bus-exclusivity and single-hot-`Rin` assertion holds throughout all scenarios.

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : proc_pkg
//  Purpose  : Shared constants and types for the processor control unit:
//             opcode values, time-step encoding and default field widths.
//  Revision : 1.0  initial release
// ============================================================================
package proc_pkg;

  // Default field widths: 3-bit opcode, 3-bit register selects (9-bit IR)
  localparam int OPW_DEF = 3;
  localparam int RW_DEF  = 3;

  // Opcodes; any value with the top bit set is reserved and runs as a no-op
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Instruction time steps
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

endpackage
`default_nettype wire

// File: rtl/proc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : proc_ctrl_if
//  Purpose  : Bundle of the control unit's datapath-facing signals. The
//             master side is the control unit; the slave side is the
//             datapath (register file, A/G registers, bus mux, adder).
//  Revision : 1.0  initial release
// ============================================================================
interface proc_ctrl_if
  import proc_pkg::*;
#(
  parameter int OPW = OPW_DEF,
  parameter int RW  = RW_DEF
);
  localparam int NREG = 2 ** RW;
  localparam int IW   = OPW + 2 * RW;

  logic [IW-1:0]   DIN;
  logic            Run;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            IRin;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic            DINout;
  logic            AddSub;
  logic            Done;

  modport master (
    input  DIN, Run,
    output Rin, Rout, IRin, Ain, Gin, Gout, DINout, AddSub, Done
  );

  modport slave (
    output DIN, Run,
    input  Rin, Rout, IRin, Ain, Gin, Gout, DINout, AddSub, Done
  );

endinterface
`default_nettype wire

// File: rtl/proc_ctrl_dec_onehot.sv
`default_nettype none
// ============================================================================
//  Module   : dec_onehot
//  Purpose  : RW-bit binary select to 2**RW one-hot decoder with enable.
//             All outputs are 0 while the enable is low.
//  Revision : 1.0  initial release
// ============================================================================
module dec_onehot #(
  parameter int RW = 3
) (
  input  wire logic               i_en,
  input  wire logic [RW-1:0]      i_sel,
  output      logic [2**RW-1:0]   o_onehot
);

  // Decode the select into a single hot bit when enabled
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/proc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : proc_ctrl
//  Purpose  : Control unit for the simple bus processor. Fetches an
//             instruction in T0 and sequences mv/mvi (T1) or add/sub (T1-T3),
//             driving register load enables and bus-source selects. All
//             outputs are combinational decodes of (Tstep, IR, Run).
//  Revision : 1.0  initial release
// ============================================================================
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int OPW = OPW_DEF,
  parameter int RW  = RW_DEF
) (
  input wire logic     clk,
  input wire logic     resetn,
  proc_ctrl_if.master  bus
);

  localparam int NREG = 2 ** RW;
  localparam int IW   = OPW + 2 * RW;

  tstep_t          r_tstep;
  tstep_t          w_tstep_nxt;
  logic [IW-1:0]   r_ir;

  logic [OPW-1:0]  w_op;
  logic [RW-1:0]   w_x;
  logic [RW-1:0]   w_y;
  logic [NREG-1:0] w_x_oh;
  logic [NREG-1:0] w_y_oh;
  logic            w_busy;
  logic            w_fetch;
  logic            w_is_mv;
  logic            w_is_mvi;
  logic            w_is_add;
  logic            w_is_sub;

  // Instruction fields: opcode, then X, then Y
  assign w_op = r_ir[IW-1 -: OPW];
  assign w_x  = r_ir[2*RW-1 -: RW];
  assign w_y  = r_ir[RW-1:0];

  assign w_is_mv  = (w_op == OPW'(OP_MV));
  assign w_is_mvi = (w_op == OPW'(OP_MVI));
  assign w_is_add = (w_op == OPW'(OP_ADD));
  assign w_is_sub = (w_op == OPW'(OP_SUB));

  // Register selects only ever matter outside T0, so the decoders idle there
  assign w_busy  = (r_tstep != T0);
  assign w_fetch = (r_tstep == T0) && bus.Run;

  dec_onehot #(.RW(RW)) u_dec_x (
    .i_en     (w_busy),
    .i_sel    (w_x),
    .o_onehot (w_x_oh)
  );

  dec_onehot #(.RW(RW)) u_dec_y (
    .i_en     (w_busy),
    .i_sel    (w_y),
    .o_onehot (w_y_oh)
  );

  // Time-step register; reset forces T0 so all enables drop immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tstep <= T0;
    end else begin
      r_tstep <= w_tstep_nxt;
    end
  end

  // Instruction register, loaded on the fetch edge only
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ir <= '0;
    end else if (w_fetch) begin
      r_ir <= bus.DIN;
    end
  end

  // Next-step and control-output decode
  always_comb begin
    w_tstep_nxt = r_tstep;
    bus.Rin     = '0;
    bus.Rout    = '0;
    bus.IRin    = 1'b0;
    bus.Ain     = 1'b0;
    bus.Gin     = 1'b0;
    bus.Gout    = 1'b0;
    bus.DINout  = 1'b0;
    bus.AddSub  = 1'b0;
    bus.Done    = 1'b0;

    case (r_tstep)
      T0: begin
        bus.IRin = bus.Run;
        if (bus.Run) begin
          w_tstep_nxt = T1;
        end
      end
      T1: begin
        if (w_is_mv) begin
          bus.Rout    = w_y_oh;
          bus.Rin     = w_x_oh;
          bus.Done    = 1'b1;
          w_tstep_nxt = T0;
        end else if (w_is_mvi) begin
          bus.DINout  = 1'b1;
          bus.Rin     = w_x_oh;
          bus.Done    = 1'b1;
          w_tstep_nxt = T0;
        end else if (w_is_add || w_is_sub) begin
          bus.Rout    = w_x_oh;
          bus.Ain     = 1'b1;
          w_tstep_nxt = T2;
        end else begin
          // Reserved opcode: complete immediately with no side effects
          bus.Done    = 1'b1;
          w_tstep_nxt = T0;
        end
      end
      T2: begin
        bus.Rout    = w_y_oh;
        bus.Gin     = 1'b1;
        bus.AddSub  = w_is_sub;
        w_tstep_nxt = T3;
      end
      T3: begin
        bus.Gout    = 1'b1;
        bus.Rin     = w_x_oh;
        bus.Done    = 1'b1;
        w_tstep_nxt = T0;
      end
      default: begin
        w_tstep_nxt = T0;
      end
    endcase
  end

endmodule
`default_nettype wire
